sink_wr_arbiter: RTL and testbench

- Shares the single Rx message-buffer write port among NREQ sink FSM channels.
- Each channel presents a message: port id, data words, last marker.
- The arbiter grants one whole message at a time, round-robin, and generates buffer addresses from the Rx region base.
- On completion it raises a new-message status and holds the buffer until the consumer acknowledges. Sits between the sink channels and the CSR/message memory.

---
 rtl/sink_wr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sink_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sink_wr_arbiter.sv
// Round-robin arbiter sharing the single Rx message-buffer write port among sink channels.
// Grants one whole message at a time and holds the buffer until the consumer acknowledges it.
module sink_wr_arbiter #(
  parameter int NREQ             = 4,
  parameter int FLIT_DATA_WIDTH  = 32,
  parameter int MSG_LENGTH       = 1024,
  parameter int CSR_LENGTH       = 40,
  parameter int START_WR_ADDRESS = MSG_LENGTH + CSR_LENGTH,
  parameter int ADDR_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [8*NREQ-1:0]               req_portid,
  input  logic [NREQ-1:0]                 req_wr_en,
  input  logic [FLIT_DATA_WIDTH*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]                 req_last,
  output logic [NREQ-1:0]                 req_grant,
  output logic                            mem_wr_en,
  output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
  output logic [FLIT_DATA_WIDTH-1:0]      mem_wr_data,
  output logic                            rx_msg_ready,
  output logic [7:0]                      rx_msg_portid,
  output logic [31:0]                     rx_msg_len,
  input  logic                            rx_ack,
  output logic                            overflow_err,
  input  logic                            err_clr
);

  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OFF_W    = $clog2(MSG_LENGTH + 1);
  localparam int MAX_ADDR = START_WR_ADDRESS + MSG_LENGTH - 1;

  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(START_WR_ADDRESS);
  localparam logic [OFF_W-1:0]      OFF_MAX    = OFF_W'(MSG_LENGTH);
  localparam logic [IDX_W-1:0]      PTR_INIT   = IDX_W'(NREQ - 1);

  // The Rx buffer sits above the CSR region and its last word must be addressable.
  if (START_WR_ADDRESS < MSG_LENGTH + CSR_LENGTH || MAX_ADDR >= (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("sink_wr_arbiter: Rx buffer placement does not fit ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_HOLD
  } state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [OFF_W-1:0] r_offset;
  logic [7:0]       r_portid;

  logic                       w_any_req;
  logic [IDX_W-1:0]           w_win;
  logic [7:0]                 w_win_portid;
  logic                       w_g_valid;
  logic                       w_g_wr;
  logic                       w_g_last;
  logic [FLIT_DATA_WIDTH-1:0] w_g_data;
  logic                       w_xfer;
  logic                       w_abort;
  logic                       w_do_write;
  logic                       w_ovf_set;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int step);
    return IDX_W'((int'(base) + step) % NREQ);
  endfunction

  // Walk from the farthest candidate back to pointer+1 so the nearest requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_any_req = 1'b0;
    w_win     = r_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[rr_index(r_ptr, k)]) begin
        w_any_req = 1'b1;
        w_win     = rr_index(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_win_portid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDX_W'(i)) w_win_portid = req_portid[8*i +: 8];
    end
  end

  // While transferring, the pointer names the granted channel.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_wr    = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_ptr == IDX_W'(i)) begin
        w_g_valid = req_valid[i];
        w_g_wr    = req_wr_en[i];
        w_g_last  = req_last[i];
        w_g_data  = req_data[FLIT_DATA_WIDTH*i +: FLIT_DATA_WIDTH];
      end
    end
  end

  assign w_xfer     = (r_state == ST_XFER);
  assign w_abort    = w_xfer && !w_g_valid && !w_g_last;
  assign w_do_write = w_xfer && !w_abort && w_g_wr && (r_offset != OFF_MAX);
  assign w_ovf_set  = w_xfer && !w_abort && w_g_wr && (r_offset == OFF_MAX);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= PTR_INIT;
      r_offset      <= '0;
      r_portid      <= '0;
      req_grant     <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      rx_msg_ready  <= 1'b0;
      rx_msg_portid <= '0;
      rx_msg_len    <= '0;
      overflow_err  <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;

      if (w_ovf_set) begin
        overflow_err <= 1'b1;
      end else if (err_clr) begin
        overflow_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            req_grant <= NREQ'(1) << w_win;
            r_portid  <= w_win_portid;
            r_offset  <= '0;
            r_ptr     <= w_win;
            r_state   <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (w_abort) begin
            req_grant <= '0;
            r_state   <= ST_IDLE;
          end else begin
            if (w_do_write) begin
              mem_wr_en   <= 1'b1;
              mem_wr_addr <= START_ADDR + ADDR_WIDTH'(r_offset);
              mem_wr_data <= w_g_data;
              r_offset    <= r_offset + OFF_W'(1);
            end
            // A word arriving with the terminator is still counted in the length.
            if (w_g_last) begin
              req_grant     <= '0;
              rx_msg_ready  <= 1'b1;
              rx_msg_portid <= r_portid;
              rx_msg_len    <= 32'(r_offset) + 32'(w_do_write);
              r_state       <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (rx_ack) begin
            rx_msg_ready <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sink_wr_arbiter.sv
// Directed bench for sink_wr_arbiter: write-port traffic is checked against a scoreboard
// queue filled as words are driven; status, grant and error flags are checked inline.
module tb_sink_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [31:0]  req_portid;
  logic [3:0]   req_wr_en;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_grant;
  logic         mem_wr_en;
  logic [15:0]  mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic         rx_msg_ready;
  logic [7:0]   rx_msg_portid;
  logic [31:0]  rx_msg_len;
  logic         rx_ack;
  logic         overflow_err;
  logic         err_clr;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  sink_wr_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_portid   (req_portid),
    .req_wr_en    (req_wr_en),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_grant    (req_grant),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .rx_msg_ready (rx_msg_ready),
    .rx_msg_portid(rx_msg_portid),
    .rx_msg_len   (rx_msg_len),
    .rx_ack       (rx_ack),
    .overflow_err (overflow_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ch, input logic v, input logic wr, input logic last,
                       input logic [7:0] pid, input logic [31:0] d);
    req_valid[ch]             = v;
    req_wr_en[ch]             = wr;
    req_last[ch]              = last;
    req_portid[{ch, 3'd0} +: 8]  = pid;
    req_data[{ch, 5'd0} +: 32]   = d;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req_grant == 4'b0000 && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(req_grant), 32'(exp));
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  // Every buffer write must match the oldest word still expected.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected observed_addr=%0d expected=none", mem_wr_addr);
      end
      if (sb_q.size() != 0) begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
        check("wr_data", mem_wr_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_portid = '0;
    req_wr_en  = '0;
    req_data   = '0;
    req_last   = '0;
    rx_ack     = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    #16;
    check("rst_grant", 32'(req_grant), 32'h0);
    check("rst_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_ready", 32'(rx_msg_ready), 32'h0);
    check("rst_len", rx_msg_len, 32'h0);
    check("rst_ovf", 32'(overflow_err), 32'h0);
    #2;
    rst_n = 1'b1;

    // Single message on ch0
    drive(2'd0, 1'b1, 1'b0, 1'b0, 8'h05, 32'h0);
    tick();
    check("t1_grant", 32'(req_grant), 32'h1);
    drive(2'd0, 1'b1, 1'b1, 1'b0, 8'h05, 32'hA); push(16'd1064, 32'hA); tick();
    drive(2'd0, 1'b1, 1'b1, 1'b0, 8'h05, 32'hB); push(16'd1065, 32'hB); tick();
    drive(2'd0, 1'b1, 1'b1, 1'b1, 8'h05, 32'hC); push(16'd1066, 32'hC); tick();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 8'h05, 32'h0);
    check("t1_ready", 32'(rx_msg_ready), 32'h1);
    check("t1_portid", 32'(rx_msg_portid), 32'h05);
    check("t1_len", rx_msg_len, 32'd3);
    check("t1_grant_off", 32'(req_grant), 32'h0);
    tick();
    check("t1_ready_held", 32'(rx_msg_ready), 32'h1);
    ack_pulse();
    check("t1_ready_ack", 32'(rx_msg_ready), 32'h0);

    // Round-robin with all channels pending; reset restores channel 0 priority
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) drive(2'(c), 1'b1, 1'b1, 1'b1, 8'(8'h10 + c), 32'hD000 + c);
    for (int m = 0; m < 5; m++) begin
      wait_grant($sformatf("t2_grant_%0d", m), 4'b0001 << (m % 4));
      push(16'd1064, 32'hD000 + (m % 4));
      tick();
      check($sformatf("t2_ready_%0d", m), 32'(rx_msg_ready), 32'h1);
      check($sformatf("t2_portid_%0d", m), 32'(rx_msg_portid), 32'(8'h10 + (m % 4)));
      check($sformatf("t2_len_%0d", m), rx_msg_len, 32'd1);
      ack_pulse();
    end
    for (int c = 0; c < 4; c++) drive(2'(c), 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // HOLD blocks a new requester until the ack
    drive(2'd0, 1'b1, 1'b0, 1'b0, 8'h30, 32'h0);
    wait_grant("t3_grant0", 4'b0001);
    drive(2'd0, 1'b1, 1'b1, 1'b1, 8'h30, 32'h3333); push(16'd1064, 32'h3333); tick();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 8'h30, 32'h0);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 8'h31, 32'h0);
    check("t3_ready", 32'(rx_msg_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_blocked_%0d", i), 32'(req_grant), 32'h0);
    end
    ack_pulse();
    check("t3_grant_ack1", 32'(req_grant), 32'h0);
    check("t3_ready_ack", 32'(rx_msg_ready), 32'h0);
    tick();
    check("t3_grant_ack2", 32'(req_grant), 32'h2);
    drive(2'd1, 1'b1, 1'b1, 1'b1, 8'h31, 32'h4444); push(16'd1064, 32'h4444); tick();
    drive(2'd1, 1'b0, 1'b0, 1'b0, 8'h31, 32'h0);
    check("t3_len", rx_msg_len, 32'd1);
    check("t3_portid", 32'(rx_msg_portid), 32'h31);
    ack_pulse();

    // Overflow: 1026 words into a 1024-word buffer
    drive(2'd2, 1'b1, 1'b0, 1'b0, 8'h42, 32'h0);
    wait_grant("t4_grant", 4'b0100);
    for (int i = 0; i < 1026; i++) begin
      drive(2'd2, 1'b1, 1'b1, (i == 1025), 8'h42, 32'h2000 + i);
      if (i < 1024) push(16'(1064 + i), 32'h2000 + i);
      tick();
    end
    drive(2'd2, 1'b0, 1'b0, 1'b0, 8'h42, 32'h0);
    check("t4_ready", 32'(rx_msg_ready), 32'h1);
    check("t4_len", rx_msg_len, 32'd1024);
    check("t4_ovf", 32'(overflow_err), 32'h1);
    check("t4_wr_en", 32'(mem_wr_en), 32'h0);
    check("t4_last_addr", 32'(mem_wr_addr), 32'd2087);
    check("t4_last_data", mem_wr_data, 32'h2000 + 1023);
    ack_pulse();
    check("t4_ovf_sticky", 32'(overflow_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow_err), 32'h0);

    // Abort: ch3 drops valid after two words
    drive(2'd3, 1'b1, 1'b0, 1'b0, 8'h53, 32'h0);
    wait_grant("t5_grant", 4'b1000);
    drive(2'd3, 1'b1, 1'b1, 1'b0, 8'h53, 32'h5000); push(16'd1064, 32'h5000); tick();
    drive(2'd3, 1'b1, 1'b1, 1'b0, 8'h53, 32'h5001); push(16'd1065, 32'h5001); tick();
    drive(2'd3, 1'b0, 1'b0, 1'b0, 8'h53, 32'h0);
    tick();
    check("t5_abort_grant", 32'(req_grant), 32'h0);
    check("t5_abort_ready", 32'(rx_msg_ready), 32'h0);
    tick();
    check("t5_idle_ready", 32'(rx_msg_ready), 32'h0);

    // Asynchronous reset in the middle of a transfer
    drive(2'd1, 1'b1, 1'b0, 1'b0, 8'h61, 32'h0);
    wait_grant("t6_grant", 4'b0010);
    drive(2'd1, 1'b1, 1'b1, 1'b0, 8'h61, 32'h6000); push(16'd1064, 32'h6000); tick();
    drive(2'd1, 1'b1, 1'b0, 1'b0, 8'h61, 32'h0);
    drive(2'd0, 1'b1, 1'b0, 1'b0, 8'h60, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(req_grant), 32'h0);
    check("t6_rst_wr_en", 32'(mem_wr_en), 32'h0);
    check("t6_rst_addr", 32'(mem_wr_addr), 32'h0);
    check("t6_rst_data", mem_wr_data, 32'h0);
    check("t6_rst_len", rx_msg_len, 32'h0);
    check("t6_rst_portid", 32'(rx_msg_portid), 32'h0);
    #1;
    rst_n = 1'b1;
    wait_grant("t6_first_grant", 4'b0001);
    drive(2'd1, 1'b0, 1'b0, 1'b0, 8'h61, 32'h0);

    // Zero-length message on ch0
    drive(2'd0, 1'b1, 1'b0, 1'b1, 8'h60, 32'h0);
    tick();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 8'h60, 32'h0);
    check("t7_ready", 32'(rx_msg_ready), 32'h1);
    check("t7_len", rx_msg_len, 32'h0);
    check("t7_portid", 32'(rx_msg_portid), 32'h60);
    check("t7_wr_en", 32'(mem_wr_en), 32'h0);
    ack_pulse();
    check("t7_ready_ack", 32'(rx_msg_ready), 32'h0);

    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
